// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage with PC, IF/ID register and sticky fault
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int          N   = 64,
    parameter logic [31:0] NOP = 32'h8b1f03ff
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    input  logic         stall,
    input  logic         flush,
    output logic [6:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [N-1:0] pc_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         fault,
    output logic [31:0]  fetch_count
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);

    state_t       state;
    logic         in_fault;
    logic         out_of_range;
    logic         misaligned;
    logic         fault_event;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_next;
    logic [31:0]  fetch_word;
    logic         fetch_real;
    logic         load_real;

    assign in_fault     = (state == FAULT);
    assign out_of_range = |pc_F[N-1:9];
    assign misaligned   = PCSrc & (|PCBranch[1:0]);
    assign fault_event  = !in_fault && (out_of_range || misaligned);
    assign pc_plus4     = pc_F + PC_STEP;
    assign imem_addr    = pc_F[8:2];
    assign fault        = in_fault;

    // A taken branch outranks stall; a misaligned target holds the PC.
    always_comb begin
        pc_next = pc_plus4;
        if (in_fault) begin
            pc_next = pc_F;
        end else if (PCSrc) begin
            pc_next = misaligned ? pc_F : PCBranch;
        end else if (stall) begin
            pc_next = pc_F;
        end
    end

    // Words fetched from outside the 512-byte memory, or after a fault, become bubbles.
    always_comb begin
        fetch_real = !in_fault && !out_of_range;
        fetch_word = fetch_real ? imem_q : NOP;
    end

    assign load_real = !flush && !stall && fetch_real;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pc_F        <= '0;
            instr_D     <= NOP;
            pc_D        <= '0;
            valid_D     <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (fault_event) begin
                state <= FAULT;
            end

            pc_F <= pc_next;

            if (flush) begin
                instr_D <= NOP;
                pc_D    <= '0;
                valid_D <= 1'b0;
            end else if (!stall) begin
                instr_D <= fetch_word;
                pc_D    <= pc_F;
                valid_D <= fetch_real;
            end

            if (load_real) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed vector bench for fetch_stage (imem[i] = i)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [63:0] PCBranch;
    logic        stall;
    logic        flush;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_q = {25'd0, imem_addr};

    fetch_stage #(.N(64), .NOP(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .PCBranch    (PCBranch),
        .stall       (stall),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .pc_F        (pc_F),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .valid_D     (valid_D),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic [63:0] e_pcd;
        logic        chk_pcd;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " pc_F"},        pc_F,                 v.e_pc);
        chk({tag, " instr_D"},     {32'd0, instr_D},     {32'd0, v.e_instr});
        if (v.chk_pcd) chk({tag, " pc_D"}, pc_D, v.e_pcd);
        chk({tag, " valid_D"},     {63'd0, valid_D},     {63'd0, v.e_valid});
        chk({tag, " fault"},       {63'd0, fault},       {63'd0, v.e_fault});
        chk({tag, " fetch_count"}, {32'd0, fetch_count}, {32'd0, v.e_cnt});
        chk({tag, " imem_addr"},   {57'd0, imem_addr},   {57'd0, v.e_pc[8:2]});
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        stall    = v.st;
        flush    = v.fl;
        PCSrc    = v.br;
        PCBranch = v.tgt;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 1, 0, 0, 32'd0});
        @(negedge clk);
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        PCSrc    = 1'b0;
        PCBranch = '0;
    endtask

    initial begin
        //          st fl br tgt      pc_F      instr  pc_D    chk v  f  cnt
        tbl[0]  = '{0, 0, 0, 64'd0,   64'd4,    32'd0,   64'd0,   1, 1, 0, 32'd1};
        tbl[1]  = '{0, 0, 0, 64'd0,   64'd8,    32'd1,   64'd4,   1, 1, 0, 32'd2};
        tbl[2]  = '{0, 0, 0, 64'd0,   64'd12,   32'd2,   64'd8,   1, 1, 0, 32'd3};
        tbl[3]  = '{0, 0, 0, 64'd0,   64'd16,   32'd3,   64'd12,  1, 1, 0, 32'd4};
        tbl[4]  = '{1, 0, 1, 64'd40,  64'd40,   32'd3,   64'd12,  1, 1, 0, 32'd4};
        tbl[5]  = '{1, 1, 0, 64'd0,   64'd40,   NOP,     64'd0,   1, 0, 0, 32'd4};
        tbl[6]  = '{0, 1, 0, 64'd0,   64'd44,   NOP,     64'd0,   1, 0, 0, 32'd4};
        tbl[7]  = '{1, 0, 0, 64'd0,   64'd44,   NOP,     64'd0,   1, 0, 0, 32'd4};
        tbl[8]  = '{0, 0, 0, 64'd0,   64'd48,   32'd11,  64'd44,  1, 1, 0, 32'd5};
        tbl[9]  = '{0, 0, 1, 64'd508, 64'd508,  32'd12,  64'd48,  1, 1, 0, 32'd6};
        tbl[10] = '{0, 0, 0, 64'd0,   64'd512,  32'd127, 64'd508, 1, 1, 0, 32'd7};
        tbl[11] = '{0, 0, 0, 64'd0,   64'd516,  NOP,     64'd0,   0, 0, 1, 32'd7};
        tbl[12] = '{0, 0, 0, 64'd0,   64'd516,  NOP,     64'd0,   0, 0, 1, 32'd7};
        tbl[13] = '{0, 0, 1, 64'd40,  64'd516,  NOP,     64'd0,   0, 0, 1, 32'd7};

        reset    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        PCSrc    = 1'b0;
        PCBranch = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 1, 0, 0, 32'd0});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("row%0d", i), tbl[i]);
        end

        // Asynchronous reset while in FAULT with every control input active.
        @(negedge clk);
        stall    = 1'b1;
        flush    = 1'b1;
        PCSrc    = 1'b1;
        PCBranch = 64'd40;
        reset    = 1'b0;
        #1;
        check_outs("async_rst", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 1, 0, 0, 32'd0});
        @(posedge clk);
        #1;
        check_outs("rst_held", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 1, 0, 0, 32'd0});
        @(negedge clk);
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        PCSrc    = 1'b0;
        PCBranch = '0;

        // Misaligned branch target.
        run_vec("mis1", '{0, 0, 0, 64'd0,  64'd4, 32'd0, 64'd0, 1, 1, 0, 32'd1});
        run_vec("mis2", '{0, 0, 0, 64'd0,  64'd8, 32'd1, 64'd4, 1, 1, 0, 32'd2});
        run_vec("mis3", '{0, 0, 1, 64'd42, 64'd8, 32'd2, 64'd8, 1, 1, 1, 32'd3});
        run_vec("mis4", '{0, 0, 0, 64'd0,  64'd8, NOP,   64'd0, 0, 0, 1, 32'd3});
        run_vec("mis5", '{1, 0, 0, 64'd0,  64'd8, NOP,   64'd0, 0, 0, 1, 32'd3});
        run_vec("mis6", '{0, 1, 0, 64'd0,  64'd8, NOP,   64'd0, 1, 0, 1, 32'd3});

        // PC adder wraps modulo 2^64; the top address is out of range.
        do_reset();
        run_vec("wrap1", '{0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
                           32'd0, 64'd0, 1, 1, 0, 32'd1});
        run_vec("wrap2", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 0, 0, 1, 32'd1});
        run_vec("wrap3", '{0, 0, 0, 64'd0, 64'd0, NOP, 64'd0, 0, 0, 1, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 64, SHALL set the datapath and PC width in bits.
REQ-002 Parameter NOP, default 32'h8b1f03ff (ADD XZR,XZR,XZR), SHALL be the bubble instruction word.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low: asserted when 0.
REQ-005 PCSrc  input  1  SHALL mean the branch is taken; the PC loads PCBranch.
REQ-006 PCBranch  input  N  SHALL carry the branch target byte address.
REQ-007 stall  input  1  SHALL hold the PC and the IF/ID register.
REQ-008 flush  input  1  SHALL load a bubble into IF/ID.
REQ-009 imem_addr  output  7  SHALL be the instruction-memory word address, equal to pc_F[8:2].
REQ-010 imem_q  input  32  SHALL be the combinational instruction word returned for imem_addr.
REQ-011 pc_F  output  N  SHALL be the current fetch PC.
REQ-012 instr_D  output  32  SHALL be the registered instruction for decode.
REQ-013 pc_D  output  N  SHALL be the registered PC of instr_D.
REQ-014 valid_D  output  1  SHALL be 1 when instr_D is a real fetched instruction, 0 for a bubble.
REQ-015 fault  output  1  SHALL be a sticky fetch fault flag.
REQ-016 fetch_count  output  32  SHALL count instructions delivered to IF/ID with valid_D=1.

Function
REQ-017 Next PC SHALL be selected in this priority: fault (hold) > PCSrc (PCBranch) > stall (hold) > pc_F+4.
- A taken branch therefore overrides stall.
REQ-018 The PC adder SHALL be N bits wide and wrap modulo 2^N with no flag raised.
REQ-019 IF/ID SHALL update in this priority:
- flush: instr_D=NOP, valid_D=0, pc_D=0.
- else stall: hold all fields.
- else: instr_D=imem_q, pc_D=pc_F, valid_D=1.
REQ-020 Flush and stall asserted together SHALL insert the bubble; flush wins.
REQ-021 Fetch-to-decode latency SHALL be exactly one cycle: the word at pc_F appears on instr_D after the next rising edge, absent stall or flush.
REQ-022 Out-of-range fetch: if pc_F >= 512 (any of bits N-1:9 set), the IF/ID load SHALL use NOP with valid_D=0 instead of imem_q.
- fault SHALL set at that edge.
REQ-023 Misaligned branch: if PCSrc=1 and PCBranch[1:0]!=0, fault SHALL set and the PC SHALL hold its current value.
REQ-024 Once fault=1, the PC SHALL freeze and every IF/ID load SHALL be a bubble until reset.
- stall still holds IF/ID.
- flush still bubbles IF/ID.
REQ-025 State machine with states RUN and FAULT SHALL control fetch:
- RUN->FAULT on the REQ-022 or REQ-023 condition.
- FAULT->RUN only on reset.
- fault SHALL equal (state==FAULT).
REQ-026 fetch_count SHALL increment by 1 on each edge loading valid_D=1, and SHALL wrap from 2^32-1 to 0.
REQ-027 imem_addr SHALL be purely combinational from pc_F, with no added latency.

Reset
REQ-028 While reset=0, outputs SHALL immediately take: pc_F=0, instr_D=NOP, pc_D=0, valid_D=0, fault=0, fetch_count=0, state=RUN.
REQ-029 Reset asserted mid-stall, mid-flush or in FAULT SHALL override all inputs.
REQ-030 After reset deasserts, the first rising edge SHALL load the word at address 0 into IF/ID and set pc_F=4.

Verification
REQ-031 Sequential fetch: release reset, model imem[i]=i, hold stall=flush=PCSrc=0 for 4 edges.
- Required: pc_F=16, instr_D=3, pc_D=12, valid_D=1, fetch_count=4.
REQ-032 Branch vs stall: at pc_F=8 assert PCSrc=1, PCBranch=40 and stall=1 for one edge.
- Required: pc_F=40; IF/ID unchanged.
REQ-033 Flush+stall: assert both for one edge.
- Required: instr_D=32'h8b1f03ff, valid_D=0; pc_F unchanged; fetch_count unchanged.
REQ-034 Faults:
- Branch to PCBranch=42: fault=1, pc_F held, later IF/ID loads are bubbles.
- Branch to 508 then run 2 edges: second load is a bubble, fault=1.
REQ-035 Async reset mid-run: drop reset between edges while in FAULT.
- Required: all REQ-028 values visible before the next clock edge.
